// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between the fetch (instr) and writeback (data) ports.
// One access in flight at a time; data has priority unless instr has been starved too long.
module mem_port_arbiter #(
   parameter int ADDR_W       = 16,
   parameter int DATA_W       = 64,
   parameter int STARVE_LIMIT = 4,
   parameter int TIMEOUT      = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              instr_req,
   input  logic [ADDR_W-1:0] instr_address,
   output logic [DATA_W-1:0] instr_rdata,
   output logic              instr_valid,
   output logic              halt_fetch,
   input  logic              data_req,
   input  logic              data_write_enable,
   input  logic [ADDR_W-1:0] data_address,
   input  logic [DATA_W-1:0] data_wdata,
   output logic [DATA_W-1:0] data_rdata,
   output logic              data_valid,
   output logic              halt_data,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_rvalid,
   output logic              err_timeout
);

   localparam int WCNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam int SCNT_W = $clog2(STARVE_LIMIT + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t              state_reg, state_next;
   logic                grant_instr_reg;
   logic                we_reg;
   logic [ADDR_W-1:0]   addr_reg;
   logic [DATA_W-1:0]   wdata_reg;
   logic [WCNT_W-1:0]   wait_cnt_reg;
   logic [SCNT_W-1:0]   starve_cnt_reg;
   logic                err_reg;
   logic [DATA_W-1:0]   instr_rdata_reg;
   logic [DATA_W-1:0]   data_rdata_reg;

   logic                pick_instr;
   logic                timeout_hit;
   logic                capture_en;
   logic [DATA_W-1:0]   capture_data;

   always_comb begin
      state_next   = state_reg;
      pick_instr   = instr_req && (!data_req || (starve_cnt_reg == SCNT_W'(STARVE_LIMIT)));
      timeout_hit  = !mem_rvalid && (wait_cnt_reg == WCNT_W'(TIMEOUT - 1));
      capture_en   = (state_reg == WAIT) && (mem_rvalid || timeout_hit);
      // Timeouts and write acks both return zero data to the requester.
      capture_data = (mem_rvalid && !we_reg) ? mem_rdata : '0;
      case (state_reg)
         IDLE:    if (instr_req || data_req) state_next = ISSUE;
         ISSUE:   state_next = WAIT;
         WAIT:    if (capture_en) state_next = RESP;
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg       <= IDLE;
         grant_instr_reg <= 1'b0;
         we_reg          <= 1'b0;
         addr_reg        <= '0;
         wdata_reg       <= '0;
         wait_cnt_reg    <= '0;
         starve_cnt_reg  <= '0;
         err_reg         <= 1'b0;
         instr_rdata_reg <= '0;
         data_rdata_reg  <= '0;
      end else begin
         state_reg <= state_next;
         case (state_reg)
            IDLE: begin
               if (instr_req || data_req) begin
                  grant_instr_reg <= pick_instr;
                  addr_reg        <= pick_instr ? instr_address : data_address;
                  we_reg          <= pick_instr ? 1'b0 : data_write_enable;
                  wdata_reg       <= pick_instr ? '0 : data_wdata;
                  if (pick_instr)
                     starve_cnt_reg <= '0;
                  else if (instr_req && (starve_cnt_reg != SCNT_W'(STARVE_LIMIT)))
                     starve_cnt_reg <= starve_cnt_reg + 1'b1;
               end
            end
            ISSUE: wait_cnt_reg <= '0;
            WAIT: begin
               if (capture_en) begin
                  if (grant_instr_reg) instr_rdata_reg <= capture_data;
                  else                 data_rdata_reg  <= capture_data;
                  if (timeout_hit) err_reg <= 1'b1;
               end else begin
                  wait_cnt_reg <= wait_cnt_reg + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign mem_req     = (state_reg == ISSUE);
   assign mem_we      = we_reg;
   assign mem_addr    = addr_reg;
   assign mem_wdata   = wdata_reg;
   assign instr_valid = (state_reg == RESP) && grant_instr_reg;
   assign data_valid  = (state_reg == RESP) && !grant_instr_reg;
   assign instr_rdata = instr_rdata_reg;
   assign data_rdata  = data_rdata_reg;
   assign halt_fetch  = instr_req & ~instr_valid;
   assign halt_data   = data_req & ~data_valid;
   assign err_timeout = err_reg;

endmodule
